stream_perf_monitor: RTL and testbench
======================================

// Module: stream_perf_monitor
// PURPOSE
//  Synthesizable, parametrised throughput monitor for one valid/ready byte stream.
//  Sits passively on a handshake (e.g. compressor input or coder output) and measures frames.
//  Per frame (first handshake .. handshake with last) it counts active cycles, transfers,
//  stall cycles, idle cycles and per-channel transfers selected by an index field.
//  Results freeze at frame end for readout; the next frame restarts them; frames are counted.
// PARAMETERS
//  CH     8   number of channels counted individually (1..256)
//  IDX_W  8   width of in_idx
//  CNT_W  32  width of every counter (>=2)
// PORTS
//  clk        in   1         clock
//  rst        in   1         asynchronous reset, active-high
//  in_valid   in   1         monitored stream valid
//  in_ready   in   1         monitored stream ready
//  in_last    in   1         monitored stream last (qualified by fire)
//  in_idx     in   IDX_W     channel index of current beat (qualified by fire)
//  clear      in   1         synchronous clear of all counters/flags/state
//  busy       out  1         1 while state==ACTIVE
//  done       out  1         one-cycle pulse after the last handshake of a frame
//  active_cnt out  CNT_W     cycles in current/last frame, first..last fire inclusive
//  xfer_cnt   out  CNT_W     handshakes in frame
//  stall_cnt  out  CNT_W     in-frame cycles with valid & !ready
//  idle_cnt   out  CNT_W     in-frame cycles with !valid
//  chan_cnt   out  CH*CNT_W  handshakes per channel; channel k at [k*CNT_W +: CNT_W]
//  frame_cnt  out  CNT_W     completed frames since reset/clear
//  sat_err    out  1         sticky: some counter reached all-ones
//  idx_err    out  1         sticky: fire with in_idx >= CH
// BEHAVIOUR
//  - fire = in_valid & in_ready. Block never drives the stream; pure observer.
//  - Reset (async, rst=1): state IDLE, all outputs and counters 0.
//  - States: IDLE (never started), ACTIVE, DONE (results frozen). All outputs registered.
//  - IDLE/DONE + fire: load active=1, xfer=1, stall=0, idle=0, chan[in_idx]=1, others 0;
//    -> DONE if in_last (single-beat frame) else -> ACTIVE. No fire: hold all values.
//  - ACTIVE, every cycle: active+=1; fire: xfer+=1, chan[in_idx]+=1;
//    else in_valid: stall+=1; else idle+=1. fire & in_last -> DONE.
//  - Invariant in ACTIVE/DONE: active_cnt == xfer_cnt + stall_cnt + idle_cnt.
//  - Entering DONE: done=1 for exactly the first DONE cycle; frame_cnt+=1 same edge.
//  - in_idx >= CH on fire: xfer still counts, no chan increment, idx_err set.
//  - Every counter saturates at 2^CNT_W-1 (no wrap); reaching it sets sat_err.
//  - clear=1: next edge -> IDLE, all counters, done, sat_err, idx_err = 0;
//    clear has priority over a simultaneous fire (that beat is not counted).
//  - in_last without fire is ignored. Reset mid-frame discards the frame.
//  - Latency: counters reflect a cycle's event on the following clk edge (1 cycle).
// TESTING
//  1. Reset, 4 beats back-to-back idx 0,1,2,3, last on 4th -> active=4 xfer=4
//     stall=0 idle=0 chan[0..3]=1, done pulse 1 cycle, frame_cnt=1, busy low after.
//  2. 3 beats with 2 !valid gaps and 1 valid&!ready cycle -> active=6 xfer=3
//     idle=2 stall=1; invariant holds every cycle.
//  3. Single beat with last, idx 5 -> DONE directly, active=1 chan[5]=1, done once;
//     second frame of 2 beats restarts counts (xfer=2), frame_cnt=2.
//  4. CNT_W=4, 20-beat frame -> xfer_cnt=15, active_cnt=15, sat_err=1, no wrap.
//  5. Fire with in_idx=9 (CH=8) -> xfer+1, no chan change, idx_err=1 sticky until clear.
//  6. clear coincident with fire mid-frame -> IDLE, all 0, beat uncounted;
//     rst asserted mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/stream_perf_monitor.sv
// Passive valid/ready frame monitor: per-frame active/xfer/stall/idle/per-channel counts, frozen at frame end.
// Latency 1 cycle (registered outputs); never drives the stream, so it exerts no backpressure.
module stream_perf_monitor #(
    parameter int CH    = 8,
    parameter int IDX_W = 8,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_ready,
    input  logic                in_last,
    input  logic [IDX_W-1:0]    in_idx,
    input  logic                clear,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    active_cnt,
    output logic [CNT_W-1:0]    xfer_cnt,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    idle_cnt,
    output logic [CH*CNT_W-1:0] chan_cnt,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                sat_err,
    output logic                idx_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] chan_q [CH];
    logic [CNT_W-1:0] chan_d [CH];
    logic             done_q, done_d;
    logic             sat_err_q, sat_err_d;
    logic             idx_err_q, idx_err_d;

    logic fire;
    logic idx_ok;
    logic any_max;

    assign fire   = in_valid & in_ready;
    assign idx_ok = 32'(in_idx) < 32'(CH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == MAX) ? x : x + ONE;
    endfunction

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        xfer_d    = xfer_q;
        stall_d   = stall_q;
        idle_d    = idle_q;
        frame_d   = frame_q;
        done_d    = 1'b0;
        idx_err_d = idx_err_q;
        for (int k = 0; k < CH; k++) begin
            chan_d[k] = chan_q[k];
        end

        if (clear) begin
            state_d   = ST_IDLE;
            active_d  = '0;
            xfer_d    = '0;
            stall_d   = '0;
            idle_d    = '0;
            frame_d   = '0;
            idx_err_d = 1'b0;
            for (int k = 0; k < CH; k++) begin
                chan_d[k] = '0;
            end
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    active_d = sat_inc(active_q);
                    if (fire) begin
                        xfer_d = sat_inc(xfer_q);
                        for (int k = 0; k < CH; k++) begin
                            if (idx_ok && in_idx == IDX_W'(k)) begin
                                chan_d[k] = sat_inc(chan_q[k]);
                            end
                        end
                        idx_err_d = idx_err_q | ~idx_ok;
                        if (in_last) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            frame_d = sat_inc(frame_q);
                        end
                    end else if (in_valid) begin
                        stall_d = sat_inc(stall_q);
                    end else begin
                        idle_d = sat_inc(idle_q);
                    end
                end
                default: begin
                    // IDLE and DONE both start a fresh frame on the next handshake
                    if (fire) begin
                        active_d  = ONE;
                        xfer_d    = ONE;
                        stall_d   = '0;
                        idle_d    = '0;
                        idx_err_d = idx_err_q | ~idx_ok;
                        for (int k = 0; k < CH; k++) begin
                            chan_d[k] = (idx_ok && in_idx == IDX_W'(k)) ? ONE : '0;
                        end
                        if (in_last) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            frame_d = sat_inc(frame_q);
                        end else begin
                            state_d = ST_ACTIVE;
                        end
                    end
                end
            endcase
        end

        any_max = (active_d == MAX) | (xfer_d == MAX) | (stall_d == MAX) |
                  (idle_d == MAX) | (frame_d == MAX);
        for (int k = 0; k < CH; k++) begin
            any_max = any_max | (chan_d[k] == MAX);
        end
        sat_err_d = clear ? 1'b0 : (sat_err_q | any_max);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            xfer_q    <= '0;
            stall_q   <= '0;
            idle_q    <= '0;
            frame_q   <= '0;
            done_q    <= 1'b0;
            sat_err_q <= 1'b0;
            idx_err_q <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                chan_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            xfer_q    <= xfer_d;
            stall_q   <= stall_d;
            idle_q    <= idle_d;
            frame_q   <= frame_d;
            done_q    <= done_d;
            sat_err_q <= sat_err_d;
            idx_err_q <= idx_err_d;
            for (int k = 0; k < CH; k++) begin
                chan_q[k] <= chan_d[k];
            end
        end
    end

    assign busy       = (state_q == ST_ACTIVE);
    assign done       = done_q;
    assign active_cnt = active_q;
    assign xfer_cnt   = xfer_q;
    assign stall_cnt  = stall_q;
    assign idle_cnt   = idle_q;
    assign frame_cnt  = frame_q;
    assign sat_err    = sat_err_q;
    assign idx_err    = idx_err_q;

    for (genvar g = 0; g < CH; g++) begin : g_chan
        assign chan_cnt[g*CNT_W +: CNT_W] = chan_q[g];
    end

endmodule

// File: tb/tb_stream_perf_monitor.sv
// Directed bench for stream_perf_monitor: default instance plus a CNT_W=4 instance for saturation.
module tb_stream_perf_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, clear;
    logic [7:0]  in_idx;

    logic        busy, done, sat_err, idx_err;
    logic [31:0] active_cnt, xfer_cnt, stall_cnt, idle_cnt, frame_cnt;
    logic [255:0] chan_cnt;

    logic        busy4, done4, sat_err4, idx_err4;
    logic [3:0]  active_cnt4, xfer_cnt4, stall_cnt4, idle_cnt4, frame_cnt4;
    logic [31:0] chan_cnt4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_perf_monitor u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_idx(in_idx), .clear(clear),
        .busy(busy), .done(done), .active_cnt(active_cnt), .xfer_cnt(xfer_cnt),
        .stall_cnt(stall_cnt), .idle_cnt(idle_cnt), .chan_cnt(chan_cnt),
        .frame_cnt(frame_cnt), .sat_err(sat_err), .idx_err(idx_err)
    );

    stream_perf_monitor #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_idx(in_idx), .clear(clear),
        .busy(busy4), .done(done4), .active_cnt(active_cnt4), .xfer_cnt(xfer_cnt4),
        .stall_cnt(stall_cnt4), .idle_cnt(idle_cnt4), .chan_cnt(chan_cnt4),
        .frame_cnt(frame_cnt4), .sat_err(sat_err4), .idx_err(idx_err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ch(input int k);
        return chan_cnt[k*32 +: 32];
    endfunction

    // Inputs applied 1 time unit after an edge; returns 1 unit after the edge that samples them.
    task automatic beat(input logic v, input logic r, input logic l, input logic [7:0] idx);
        in_valid = v;
        in_ready = r;
        in_last  = l;
        in_idx   = idx;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        beat(1'b0, 1'b0, 1'b0, 8'd0);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        in_valid = 1'b0; in_ready = 1'b0; in_last = 1'b0; in_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_active", active_cnt, 0);
        chk("rst_frame", frame_cnt, 0);
        rst = 1'b0;
        beat(1'b0, 1'b0, 1'b0, 8'd0);
        chk("idle_hold_xfer", xfer_cnt, 0);

        // 1: four back-to-back beats
        beat(1'b1, 1'b1, 1'b0, 8'd0);
        chk("t1_busy", 32'(busy), 1);
        beat(1'b1, 1'b1, 1'b0, 8'd1);
        beat(1'b1, 1'b1, 1'b0, 8'd2);
        beat(1'b1, 1'b1, 1'b1, 8'd3);
        chk("t1_active", active_cnt, 4);
        chk("t1_xfer", xfer_cnt, 4);
        chk("t1_stall", stall_cnt, 0);
        chk("t1_idle", idle_cnt, 0);
        for (int k = 0; k < 4; k++) chk("t1_chan", ch(k), 1);
        chk("t1_chan4", ch(4), 0);
        chk("t1_done", 32'(done), 1);
        chk("t1_frame", frame_cnt, 1);
        chk("t1_busy_after", 32'(busy), 0);
        beat(1'b0, 1'b0, 1'b1, 8'd0);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_frozen", active_cnt, 4);

        // 2: gaps and a stall
        beat(1'b1, 1'b1, 1'b0, 8'd0);
        chk("t2_inv", active_cnt, xfer_cnt + stall_cnt + idle_cnt);
        beat(1'b0, 1'b1, 1'b1, 8'd0);
        chk("t2_inv", active_cnt, xfer_cnt + stall_cnt + idle_cnt);
        beat(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t2_inv", active_cnt, xfer_cnt + stall_cnt + idle_cnt);
        beat(1'b1, 1'b0, 1'b1, 8'd1);
        chk("t2_inv", active_cnt, xfer_cnt + stall_cnt + idle_cnt);
        beat(1'b1, 1'b1, 1'b0, 8'd1);
        chk("t2_inv", active_cnt, xfer_cnt + stall_cnt + idle_cnt);
        beat(1'b1, 1'b1, 1'b1, 8'd2);
        chk("t2_active", active_cnt, 6);
        chk("t2_xfer", xfer_cnt, 3);
        chk("t2_idle", idle_cnt, 2);
        chk("t2_stall", stall_cnt, 1);
        chk("t2_chan0", ch(0), 1);
        chk("t2_chan1", ch(1), 1);
        chk("t2_chan3", ch(3), 0);
        chk("t2_frame", frame_cnt, 2);

        // 3: single-beat frame then a two-beat frame
        do_clear();
        chk("t3_clr_frame", frame_cnt, 0);
        beat(1'b1, 1'b1, 1'b1, 8'd5);
        chk("t3_busy", 32'(busy), 0);
        chk("t3_done", 32'(done), 1);
        chk("t3_active", active_cnt, 1);
        chk("t3_chan5", ch(5), 1);
        chk("t3_frame", frame_cnt, 1);
        beat(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t3_done_once", 32'(done), 0);
        beat(1'b1, 1'b1, 1'b0, 8'd6);
        beat(1'b1, 1'b1, 1'b1, 8'd6);
        chk("t3_xfer2", xfer_cnt, 2);
        chk("t3_active2", active_cnt, 2);
        chk("t3_chan5_rst", ch(5), 0);
        chk("t3_chan6", ch(6), 2);
        chk("t3_frame2", frame_cnt, 2);

        // 4: saturation on the 4-bit instance
        do_clear();
        for (int i = 0; i < 20; i++) beat(1'b1, 1'b1, (i == 19), 8'd0);
        chk("t4_xfer_sat", 32'(xfer_cnt4), 15);
        chk("t4_active_sat", 32'(active_cnt4), 15);
        chk("t4_chan_sat", chan_cnt4[3:0], 15);
        chk("t4_sat_err", 32'(sat_err4), 1);
        chk("t4_frame4", 32'(frame_cnt4), 1);
        chk("t4_wide_xfer", xfer_cnt, 20);
        chk("t4_wide_sat", 32'(sat_err), 0);

        // 5: out-of-range index
        do_clear();
        chk("t5_sat_cleared", 32'(sat_err4), 0);
        beat(1'b1, 1'b1, 1'b0, 8'd9);
        chk("t5_xfer", xfer_cnt, 1);
        chk("t5_chan_none", 32'(|chan_cnt), 0);
        chk("t5_idx_err", 32'(idx_err), 1);
        beat(1'b1, 1'b1, 1'b1, 8'd1);
        chk("t5_xfer2", xfer_cnt, 2);
        chk("t5_chan1", ch(1), 1);
        beat(1'b1, 1'b1, 1'b1, 8'd2);
        chk("t5_idx_sticky", 32'(idx_err), 1);
        do_clear();
        chk("t5_idx_clr", 32'(idx_err), 0);

        // 6: clear colliding with a fire, then async reset mid-frame
        beat(1'b1, 1'b1, 1'b0, 8'd0);
        beat(1'b1, 1'b1, 1'b0, 8'd1);
        clear = 1'b1;
        beat(1'b1, 1'b1, 1'b0, 8'd2);
        clear = 1'b0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_active", active_cnt, 0);
        chk("t6_xfer", xfer_cnt, 0);
        chk("t6_chan2", ch(2), 0);
        chk("t6_chan0", ch(0), 0);
        beat(1'b1, 1'b1, 1'b0, 8'd3);
        beat(1'b1, 1'b1, 1'b0, 8'd3);
        chk("t6_pre_rst", xfer_cnt, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_xfer", xfer_cnt, 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_chan3", ch(3), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
